// File: rtl/matrix_keypad_scanner_pkg.sv
// Shared constants, state encodings and column helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;

  localparam logic [3:0] ROW_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_state_e;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_e;

  typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_MULTI} frame_class_e;

  // Number of low (pressed) columns, saturated at 2 since only 0/1/many matters.
  function automatic logic [1:0] low_count(input logic [3:0] col_n);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~col_n[i]};
    end
    return (n > 3'd1) ? 2'd2 : n[1:0];
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] col_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/matrix_keypad_scanner_if.sv
// Keypad-side and key-event signals of the scanner, with a debug view of the debounce FSM.
interface matrix_keypad_scanner_if;
  import keypad_pkg::*;

  // KEY_VALID is a one-cycle strobe with no ready/backpressure: the consumer must
  // take KEY_CODE in the cycle KEY_VALID is high; KEY_CODE stays stable afterwards.
  logic [3:0]            COL;
  logic [3:0]            ROW;
  logic [KEY_CODE_W-1:0] KEY_CODE;
  logic                  KEY_VALID;
  logic                  KEY_HELD;
  deb_state_e            dbg_state;

  modport master (input COL, output ROW, output KEY_CODE, output KEY_VALID,
                  output KEY_HELD, output dbg_state);
  modport slave  (output COL, input ROW, input KEY_CODE, input KEY_VALID,
                  input KEY_HELD, input dbg_state);

endinterface

// File: rtl/matrix_keypad_scanner_scan_tick_gen.sv
// Free-running divider: tick is high on the last cycle of every SCAN_DIV-cycle row period.
module scan_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  localparam int CNT_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// 4x4 active-low keypad scanner: row strobing, per-frame hit classification and
// frame-level debounce producing a key-code strobe and a held level.
module matrix_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE = 5
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  matrix_keypad_scanner_if.master  kp
);

  localparam int CNT_W = (DEBOUNCE < 3) ? 1 : $clog2(DEBOUNCE);

  logic [3:0]            col_meta_q, col_sync_q;
  logic                  tick;
  row_state_e            row_state_q, row_state_d;
  logic [3:0]            row_q, row_d;
  logic [1:0]            hit_cnt_q, hit_cnt_d;
  logic [KEY_CODE_W-1:0] frame_code_q, frame_code_d;
  deb_state_e            deb_state_q, deb_state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [KEY_CODE_W-1:0] cand_q, cand_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_held_q, key_held_d;

  logic [1:0]            row_hits, frame_hits;
  logic [2:0]            hit_sum;
  logic [KEY_CODE_W-1:0] row_code, frame_code;
  logic                  frame_end;
  frame_class_e          frame_class;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (tick)
  );

  always_comb begin
    row_state_d = row_state_q;
    if (tick) begin
      case (row_state_q)
        ROW0:    row_state_d = ROW1;
        ROW1:    row_state_d = ROW2;
        ROW2:    row_state_d = ROW3;
        default: row_state_d = ROW0;
      endcase
    end
    row_d = ROW_DRIVE[int'(row_state_d)];
  end

  // The frame-end classification folds in the ROW3 sample taken on the same tick.
  always_comb begin
    row_hits     = low_count(col_sync_q);
    row_code     = {row_state_q, first_low(col_sync_q)};
    hit_sum      = {1'b0, hit_cnt_q} + {1'b0, row_hits};
    frame_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_code   = (row_hits != 2'd0) ? row_code : frame_code_q;
    frame_end    = tick && (row_state_q == ROW3);
    hit_cnt_d    = hit_cnt_q;
    frame_code_d = frame_code_q;
    if (tick) begin
      hit_cnt_d    = frame_end ? 2'd0 : frame_hits;
      frame_code_d = frame_code;
    end
    frame_class = CLS_NONE;
    if (frame_hits == 2'd1)      frame_class = CLS_ONE;
    else if (frame_hits == 2'd2) frame_class = CLS_MULTI;
  end

  always_comb begin
    deb_state_d = deb_state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (frame_end) begin
      case (deb_state_q)
        IDLE: begin
          if (frame_class == CLS_ONE) begin
            cand_d = frame_code;
            if (DEBOUNCE == 1) begin
              deb_state_d = HELD;
              cnt_d       = '0;
              key_code_d  = frame_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              deb_state_d = PRESS_WAIT;
              cnt_d       = CNT_W'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (frame_class == CLS_ONE && frame_code == cand_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
              deb_state_d = HELD;
              cnt_d       = '0;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            deb_state_d = IDLE;
            cnt_d       = '0;
          end
        end
        HELD: begin
          if (frame_class == CLS_NONE) begin
            if (DEBOUNCE == 1) begin
              deb_state_d = IDLE;
              cnt_d       = '0;
              key_held_d  = 1'b0;
            end else begin
              deb_state_d = RELEASE_WAIT;
              cnt_d       = CNT_W'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (frame_class == CLS_NONE) begin
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
              deb_state_d = IDLE;
              cnt_d       = '0;
              key_held_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            deb_state_d = HELD;
            cnt_d       = '0;
          end
        end
        default: begin
          deb_state_d = IDLE;
          cnt_d       = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_meta_q   <= 4'hF;
      col_sync_q   <= 4'hF;
      row_state_q  <= ROW0;
      row_q        <= 4'b1110;
      hit_cnt_q    <= 2'd0;
      frame_code_q <= '0;
      deb_state_q  <= IDLE;
      cnt_q        <= '0;
      cand_q       <= '0;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
    end else begin
      col_meta_q   <= kp.COL;
      col_sync_q   <= col_meta_q;
      row_state_q  <= row_state_d;
      row_q        <= row_d;
      hit_cnt_q    <= hit_cnt_d;
      frame_code_q <= frame_code_d;
      deb_state_q  <= deb_state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
    end
  end

  assign kp.ROW       = row_q;
  assign kp.KEY_CODE  = key_code_q;
  assign kp.KEY_VALID = key_valid_q;
  assign kp.KEY_HELD  = key_held_q;
  assign kp.dbg_state = deb_state_q;

endmodule
